// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared defaults, source indices and helpers for the common
//               data bus arbiter and its per-source FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Default geometry of the CDB
  localparam int CDB_NUM_SRC    = 3;
  localparam int CDB_NUM_BUS    = 1;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam int CDB_ROB_WIDTH  = 5;   // matches the core ROB index width
  localparam int CDB_DATA_WIDTH = 32;

  // Producer channel assignment on the CDB
  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_MUL = 2'd2
  } cdb_src_e;

  // (base + off) mod n, for base < n and off <= n
  function automatic int cdb_wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_fifo
// Description : Single-source synchronous result FIFO for the CDB arbiter.
//               Full is derived from the registered count only, so a full
//               FIFO never accepts even while it is being popped.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_fifo #(
  parameter int DEPTH      = 4,
  parameter int ROB_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ROB_WIDTH-1:0]  push_rob_id,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_set_jump_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ROB_WIDTH-1:0]  head_rob_id,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_set_jump_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   C_FULL    = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   C_CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] C_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [ROB_WIDTH-1:0]  r_rob_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic                  r_jump_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W:0]        r_count;

  logic w_push;
  logic w_pop;

  assign full  = (r_count == C_FULL);
  assign empty = (r_count == '0);

  // Flush wins over both push and pop; everything is frozen when rdy_in is low
  assign w_push = rdy_in & ~flush & push & ~full;
  assign w_pop  = rdy_in & ~flush & pop  & ~empty;

  assign head_rob_id        = r_rob_mem[r_rd_ptr];
  assign head_data          = r_data_mem[r_rd_ptr];
  assign head_set_jump_addr = r_jump_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_rob_mem[r_wr_ptr]  <= push_rob_id;
      r_data_mem[r_wr_ptr] <= push_data;
      r_jump_mem[r_wr_ptr] <= push_set_jump_addr;
    end
  end

endmodule : cdb_fifo
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Buffers results from NUM_SRC
//               producers and broadcasts up to NUM_BUS per cycle, picking
//               non-empty sources in round-robin order starting at rr.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int NUM_BUS    = CDB_NUM_BUS,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int ROB_WIDTH  = CDB_ROB_WIDTH,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ROB_WIDTH-1:0]  src_rob_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_set_jump_addr,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [NUM_BUS-1:0]            bus_en,
  output logic [NUM_BUS*ROB_WIDTH-1:0]  bus_rob_id,
  output logic [NUM_BUS*DATA_WIDTH-1:0] bus_data,
  output logic [NUM_BUS-1:0]            bus_set_jump_addr
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]    w_full;
  logic [NUM_SRC-1:0]    w_empty;
  logic [NUM_SRC-1:0]    w_pop;
  logic [ROB_WIDTH-1:0]  w_head_rob  [NUM_SRC];
  logic [DATA_WIDTH-1:0] w_head_data [NUM_SRC];
  logic                  w_head_jump [NUM_SRC];

  logic [NUM_BUS-1:0]    w_port_vld;
  logic [ROB_WIDTH-1:0]  w_port_rob  [NUM_BUS];
  logic [DATA_WIDTH-1:0] w_port_data [NUM_BUS];
  logic                  w_port_jump [NUM_BUS];
  logic [RR_W-1:0]       w_rr_nxt;
  int                    w_used;

  logic [RR_W-1:0]       r_rr;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      cdb_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ROB_WIDTH  (ROB_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .flush              (flush),
        .push               (src_valid[gi]),
        .pop                (w_pop[gi]),
        .push_rob_id        (src_rob_id[gi*ROB_WIDTH +: ROB_WIDTH]),
        .push_data          (src_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .push_set_jump_addr (src_set_jump_addr[gi]),
        .full               (w_full[gi]),
        .empty              (w_empty[gi]),
        .head_rob_id        (w_head_rob[gi]),
        .head_data          (w_head_data[gi]),
        .head_set_jump_addr (w_head_jump[gi])
      );
      assign src_ready[gi] = ~w_full[gi];
    end
  endgenerate

  // Round-robin grant: walk sources from rr, give each non-empty head the next free port
  always_comb begin
    w_pop      = '0;
    w_port_vld = '0;
    w_rr_nxt   = r_rr;
    w_used     = 0;
    for (int b = 0; b < NUM_BUS; b++) begin
      w_port_rob[b]  = '0;
      w_port_data[b] = '0;
      w_port_jump[b] = 1'b0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((s == cdb_wrap_idx(int'(r_rr), k, NUM_SRC)) && !w_empty[s] && (w_used < NUM_BUS)) begin
          w_pop[s] = 1'b1;
          for (int b = 0; b < NUM_BUS; b++) begin
            if (b == w_used) begin
              w_port_vld[b]  = 1'b1;
              w_port_rob[b]  = w_head_rob[s];
              w_port_data[b] = w_head_data[s];
              w_port_jump[b] = w_head_jump[s];
            end
          end
          w_rr_nxt = RR_W'(cdb_wrap_idx(s, 1, NUM_SRC));
          w_used   = w_used + 1;
        end
      end
    end
  end

  // Bus registers and rr; idle ports keep their last payload with bus_en low
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rr              <= '0;
      bus_en            <= '0;
      bus_rob_id        <= '0;
      bus_data          <= '0;
      bus_set_jump_addr <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_rr   <= '0;
        bus_en <= '0;
      end else begin
        r_rr   <= w_rr_nxt;
        bus_en <= w_port_vld;
        for (int b = 0; b < NUM_BUS; b++) begin
          if (w_port_vld[b]) begin
            bus_rob_id[b*ROB_WIDTH +: ROB_WIDTH]    <= w_port_rob[b];
            bus_data[b*DATA_WIDTH +: DATA_WIDTH]    <= w_port_data[b];
            bus_set_jump_addr[b]                    <= w_port_jump[b];
          end
        end
      end
    end
  end

endmodule : cdb_arbiter
`default_nettype wire
